// File: rtl/iic_pkg.sv
// Shared encodings for the IIC byte-level controller: commands and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package iic_pkg;

  // Command codes presented on cmd
  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } cmd_e;

  // Controller FSM states; each non-IDLE state lasts one SCL half-period
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    START_A = 4'd1,
    START_B = 4'd2,
    BIT_LO  = 4'd3,
    BIT_HI  = 4'd4,
    ACK_LO  = 4'd5,
    ACK_HI  = 4'd6,
    STOP_A  = 4'd7,
    STOP_B  = 4'd8,
    STOP_C  = 4'd9
  } state_e;

  localparam logic [2:0] BIT_CNT_INIT = 3'd7;

endpackage

// File: rtl/iic_byte_ctrl.sv
// IIC byte controller: executes START/STOP/WRITE/READ as SCL/SDA open-drain enables.
// Latency: START 2, STOP 3, WRITE/READ 18 half-period pulses from accept to done.
// Backpressure: cmd_ready low while busy; cmd_valid while busy is dropped, never queued.
module iic_byte_ctrl
  import iic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       half_clk_pulse,
  output logic       div_en,
  input  logic [1:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] tx_byte,
  input  logic       ack_in,
  output logic [7:0] rx_byte,
  output logic       ack_out,
  output logic       done,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  state_e     state_q, state_d;
  cmd_e       cmd_q, cmd_d;
  logic [7:0] data_q, data_d;
  logic       ack_in_q, ack_in_d;
  logic [2:0] cnt_q, cnt_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;
  logic [7:0] rx_q, rx_d;
  logic       ack_out_q, ack_out_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  // Next state plus next values of every registered output; outputs are
  // computed for the state being entered so they appear with the state.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    ack_in_d  = ack_in_q;
    cnt_d     = cnt_q;
    scl_d     = scl_q;
    sda_d     = sda_q;
    rx_d      = rx_q;
    ack_out_d = ack_out_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // SCL/SDA hold whatever the last command left on the bus
        if (cmd_valid) begin
          cmd_d    = cmd_e'(cmd);
          data_d   = tx_byte;
          ack_in_d = ack_in;
          cnt_d    = BIT_CNT_INIT;
          case (cmd_e'(cmd))
            CMD_START: begin
              state_d = START_A;
              scl_d   = 1'b0;
              sda_d   = 1'b1;
            end
            CMD_STOP: begin
              state_d = STOP_A;
              scl_d   = 1'b1;
              sda_d   = 1'b1;
            end
            CMD_WRITE: begin
              // Always pull SCL low first, even from a released-SCL idle
              state_d = BIT_LO;
              scl_d   = 1'b1;
              sda_d   = ~tx_byte[7];
            end
            default: begin
              state_d = BIT_LO;
              scl_d   = 1'b1;
              sda_d   = 1'b0;
            end
          endcase
        end
      end

      START_A: if (half_clk_pulse) begin
        state_d = START_B;
        scl_d   = 1'b1;
        sda_d   = 1'b1;
      end

      START_B: if (half_clk_pulse) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end

      BIT_LO: if (half_clk_pulse) begin
        // Release SCL; SDA stays stable across the high phase
        state_d = BIT_HI;
        scl_d   = 1'b0;
      end

      BIT_HI: if (half_clk_pulse) begin
        if (cmd_q == CMD_READ) begin
          rx_d = {rx_q[6:0], sda_in};
        end
        if (cnt_q == 3'd0) begin
          state_d = ACK_LO;
          scl_d   = 1'b1;
          sda_d   = (cmd_q == CMD_READ) ? ~ack_in_q : 1'b0;
        end else begin
          state_d = BIT_LO;
          cnt_d   = cnt_q - 3'd1;
          scl_d   = 1'b1;
          sda_d   = (cmd_q == CMD_WRITE) ? ~data_q[cnt_q - 3'd1] : 1'b0;
        end
      end

      ACK_LO: if (half_clk_pulse) begin
        state_d = ACK_HI;
        scl_d   = 1'b0;
      end

      ACK_HI: if (half_clk_pulse) begin
        if (cmd_q == CMD_WRITE) begin
          ack_out_d = sda_in;
        end
        // Park with SCL low so the slave cannot start another bit
        state_d = IDLE;
        scl_d   = 1'b1;
        done_d  = 1'b1;
      end

      STOP_A: if (half_clk_pulse) begin
        state_d = STOP_B;
        scl_d   = 1'b0;
        sda_d   = 1'b1;
      end

      STOP_B: if (half_clk_pulse) begin
        // SDA rising while SCL is high is the STOP condition
        state_d = STOP_C;
        scl_d   = 1'b0;
        sda_d   = 1'b0;
      end

      STOP_C: if (half_clk_pulse) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
        scl_d   = 1'b0;
        sda_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, latched command and registered outputs; reset releases the bus
  // and drops any command in flight without a done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= CMD_START;
      data_q    <= 8'h00;
      ack_in_q  <= 1'b0;
      cnt_q     <= BIT_CNT_INIT;
      scl_q     <= 1'b0;
      sda_q     <= 1'b0;
      rx_q      <= 8'h00;
      ack_out_q <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      ack_in_q  <= ack_in_d;
      cnt_q     <= cnt_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      rx_q      <= rx_d;
      ack_out_q <= ack_out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign div_en    = busy_q;
  assign cmd_ready = ~busy_q;
  assign scl_oe    = scl_q;
  assign sda_oe    = sda_q;
  assign rx_byte   = rx_q;
  assign ack_out   = ack_out_q;
  assign done      = done_q;

endmodule
